cb_portb_wr_seq: RTL and testbench
==================================

CB_PORTB_WR_SEQ -- requirements
Module: cb_portb_wr_seq

Interface
REQ-001 SHALL have parameter L, default 4: number of CB banks/lanes.
REQ-002 SHALL have parameter RSA_DW, default 16: lane data width.
REQ-003 SHALL have parameter CB_AW, default 10: per-bank address width.
REQ-004 SHALL have parameter LEN_W, default 6: row-count width.
REQ-005 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-006 SHALL have port sys_rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port wr_start  input  1  burst request pulse.
REQ-008 SHALL have port wr_base_addr  input  CB_AW  first row address, sampled on an accepted start.
REQ-009 SHALL have port wr_len  input  LEN_W  rows in the burst, sampled on an accepted start.
REQ-010 SHALL have port wr_dir  input  2  direction: 00 IDLE, 01 POS, 10 NEG, 11 NEW; sampled on an accepted start.
REQ-011 SHALL have port landmark_num_10  input  2  lane-pair select for NEW; sampled on an accepted start.
REQ-012 SHALL have port in_valid  input  1  the mapped row on CB_dinb is valid this cycle.
REQ-013 SHALL have port CB_dinb  input  L*RSA_DW  mapped row data from the upstream dinb map stage.
REQ-014 SHALL have port CB_enb  output  L  per-bank port-B enable.
REQ-015 SHALL have port CB_web  output  L  per-bank port-B write enable.
REQ-016 SHALL have port CB_addrb  output  L*CB_AW  per-bank address; lane i in bits [i*CB_AW +: CB_AW].
REQ-017 SHALL have port CB_dinb_q  output  L*RSA_DW  registered write data.
REQ-018 SHALL have port wr_busy  output  1  high from the cycle after an accepted start until DONE is left.
REQ-019 SHALL have port wr_done  output  1  one-cycle completion pulse.

Function
REQ-020 SHALL implement FSM states IDLE, WRITE, DONE.
REQ-021 SHALL accept wr_start only in IDLE; IDLE->WRITE when wr_len!=0 and wr_dir!=00, otherwise IDLE->DONE with no write.
REQ-022 SHALL ignore wr_start in WRITE and DONE, with no change to latched parameters.
REQ-023 SHALL keep a row counter cnt, cleared on an accepted start and incremented only on in_valid in WRITE.
REQ-024 SHALL, on in_valid in WRITE, register one write whose outputs appear the next cycle (latency 1).
REQ-025 SHALL compute row address = base+cnt for POS and NEW, and base-cnt for NEG, modulo 2^CB_AW (wrap-around, no saturation).
REQ-026 SHALL drive the same address on all lanes of the write.
REQ-027 SHALL assert CB_enb/CB_web on all L lanes for POS and NEG.
REQ-028 SHALL, for NEW, assert lanes 0,1 when landmark_num_10 is 11 or 10, and lanes 2,3 when it is 00 or 01; other lanes stay 0.
REQ-029 SHALL register CB_dinb into CB_dinb_q unmodified on every accepted write.
REQ-030 SHALL move WRITE->DONE on the in_valid cycle where cnt==wr_len-1.
REQ-031 SHALL hold DONE for exactly one cycle with wr_done=1, then return to IDLE.
REQ-032 SHALL drive CB_enb and CB_web to 0 in every cycle without a registered write; CB_addrb and CB_dinb_q hold their last values.
REQ-033 SHALL ignore in_valid outside WRITE, with no write issued.

Reset
REQ-034 SHALL, on sys_rst asserted at any time, including mid-burst, asynchronously force the FSM to IDLE and cnt to 0.
REQ-035 SHALL, on sys_rst, asynchronously force CB_enb, CB_web, CB_addrb, CB_dinb_q, wr_busy and wr_done to 0.
REQ-036 SHALL not resume an aborted burst after reset; the next burst starts only on a new wr_start.

Configuration
REQ-037 SHALL, when CB_WR_ERR_EN is defined, add output wr_err (1 bit, reset 0), set sticky on in_valid in IDLE or DONE and cleared on the next accepted start.
REQ-038 SHALL, when CB_WR_ERR_EN is undefined, have no wr_err port and no error logic, with all other behaviour identical.

Verification
REQ-039 SHALL cover: POS, base=5, len=3, in_valid 3 consecutive cycles -> addresses 5,6,7; CB_web=1111 each; wr_done 1 cycle after the 3rd write.
REQ-040 SHALL cover: NEG, base=1, len=3 -> addresses 1,0,1023 (wrap); CB_web=1111.
REQ-041 SHALL cover: NEW, landmark_num_10=01, base=20, len=2 -> CB_web=1100 at addresses 20,21; with landmark_num_10=10 -> CB_web=0011.
REQ-042 SHALL cover: len=0 start -> wr_done next cycle, CB_web never asserted; a wr_start during WRITE is ignored.
REQ-043 SHALL cover: sys_rst asserted after 2 of 4 rows -> all outputs 0 immediately, FSM IDLE, no further writes.
REQ-044 SHALL cover, with CB_WR_ERR_EN defined: in_valid pulse in IDLE -> wr_err=1, held until the next wr_start.

Source files
------------

// File: rtl/cb_portb_wr_seq.sv
// -----------------------------------------------------------------------------
// cb_portb_wr_seq
//   Port-B write sequencer for the L-bank CB buffer. A burst request latches a
//   base row address, a row count, a direction and a lane-pair select. Each
//   valid mapped row arriving on CB_dinb then becomes one registered write
//   (latency 1) to the same address on all enabled lanes. Row addresses step
//   up (POS/NEW) or down (NEG) from the base, modulo 2^CB_AW.
//
// Parameters
//   L      : number of CB banks/lanes
//   RSA_DW : lane data width
//   CB_AW  : per-bank address width
//   LEN_W  : row-count width
//
// Ports
//   clk             : clock, rising edge
//   sys_rst         : asynchronous active-high reset
//   wr_start        : burst request pulse (accepted only in IDLE)
//   wr_base_addr    : first row address
//   wr_len          : rows in the burst
//   wr_dir          : 00 IDLE, 01 POS, 10 NEG, 11 NEW
//   landmark_num_10 : lane-pair select for NEW
//   in_valid        : mapped row on CB_dinb is valid
//   CB_dinb         : mapped row data
//   CB_enb/CB_web   : per-bank port-B enable / write enable
//   CB_addrb        : per-bank address, lane i at [i*CB_AW +: CB_AW]
//   CB_dinb_q       : registered write data
//   wr_busy         : burst in progress (WRITE or DONE)
//   wr_done         : one-cycle completion pulse
//   wr_err          : only with CB_WR_ERR_EN defined; sticky flag for in_valid
//                     seen outside WRITE, cleared by the next accepted start
//
// Build option macro: CB_WR_ERR_EN
// -----------------------------------------------------------------------------
module cb_portb_wr_seq #(
  parameter int L      = 4,
  parameter int RSA_DW = 16,
  parameter int CB_AW  = 10,
  parameter int LEN_W  = 6
) (
  input  logic                  clk,
  input  logic                  sys_rst,
  input  logic                  wr_start,
  input  logic [CB_AW-1:0]      wr_base_addr,
  input  logic [LEN_W-1:0]      wr_len,
  input  logic [1:0]            wr_dir,
  input  logic [1:0]            landmark_num_10,
  input  logic                  in_valid,
  input  logic [L*RSA_DW-1:0]   CB_dinb,
  output logic [L-1:0]          CB_enb,
  output logic [L-1:0]          CB_web,
  output logic [L*CB_AW-1:0]    CB_addrb,
  output logic [L*RSA_DW-1:0]   CB_dinb_q,
  output logic                  wr_busy,
  output logic                  wr_done
`ifdef CB_WR_ERR_EN
  ,
  output logic                  wr_err
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DONE} state_t;
  typedef enum logic [1:0] {DIR_IDLE, DIR_POS, DIR_NEG, DIR_NEW} dir_t;

  state_t             state, state_nx;
  dir_t               dir_q;
  logic [CB_AW-1:0]   base_q;
  logic [LEN_W-1:0]   len_q;
  logic [1:0]         lm_q;
  logic [LEN_W-1:0]   cnt;

  logic               accept;
  logic               fire;
  logic [L-1:0]       lane_mask;
  logic [CB_AW-1:0]   cnt_ext;
  logic [CB_AW-1:0]   addr_nx;

  // Next-state and per-cycle strobes
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    fire     = 1'b0;
    case (state)
      S_IDLE: begin
        if (wr_start) begin
          accept   = 1'b1;
          // Zero-length or IDLE-direction requests complete without writing
          state_nx = (wr_len != '0 && wr_dir != 2'b00) ? S_WRITE : S_DONE;
        end
      end
      S_WRITE: begin
        if (in_valid) begin
          fire = 1'b1;
          if (cnt == len_q - LEN_W'(1)) state_nx = S_DONE;
        end
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Lane enables: all lanes for POS/NEG; NEW picks lanes 0,1 when the
  // landmark select MSB is set, otherwise lanes 2,3.
  always_comb begin
    lane_mask = '0;
    for (int unsigned i = 0; i < L; i++) begin
      if (dir_q == DIR_NEW)
        lane_mask[i] = lm_q[1] ? (i < 2) : (i == 2 || i == 3);
      else
        lane_mask[i] = 1'b1;
    end
  end

  assign cnt_ext = CB_AW'(cnt);
  assign addr_nx = (dir_q == DIR_NEG) ? (base_q - cnt_ext) : (base_q + cnt_ext);

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      state     <= S_IDLE;
      dir_q     <= DIR_IDLE;
      base_q    <= '0;
      len_q     <= '0;
      lm_q      <= '0;
      cnt       <= '0;
      CB_enb    <= '0;
      CB_web    <= '0;
      CB_addrb  <= '0;
      CB_dinb_q <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        dir_q  <= dir_t'(wr_dir);
        base_q <= wr_base_addr;
        len_q  <= wr_len;
        lm_q   <= landmark_num_10;
        cnt    <= '0;
      end
      if (fire) begin
        cnt       <= cnt + LEN_W'(1);
        CB_enb    <= lane_mask;
        CB_web    <= lane_mask;
        CB_addrb  <= {L{addr_nx}};
        CB_dinb_q <= CB_dinb;
      end else begin
        CB_enb <= '0;
        CB_web <= '0;
      end
    end
  end

  // Decoded from state so the async reset clears them immediately
  assign wr_busy = (state != S_IDLE);
  assign wr_done = (state == S_DONE);

`ifdef CB_WR_ERR_EN
  // A stray row in the same cycle as an accepted start still flags
  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst)
      wr_err <= 1'b0;
    else
      wr_err <= (accept ? 1'b0 : wr_err) | (in_valid && state != S_WRITE);
  end
`endif

endmodule

// File: tb/tb_cb_portb_wr_seq.sv
module tb_cb_portb_wr_seq;

  localparam int L      = 4;
  localparam int RSA_DW = 16;
  localparam int CB_AW  = 10;
  localparam int LEN_W  = 6;

  logic                clk = 1'b0;
  logic                sys_rst;
  logic                wr_start;
  logic [CB_AW-1:0]    wr_base_addr;
  logic [LEN_W-1:0]    wr_len;
  logic [1:0]          wr_dir;
  logic [1:0]          landmark_num_10;
  logic                in_valid;
  logic [L*RSA_DW-1:0] CB_dinb;
  logic [L-1:0]        CB_enb;
  logic [L-1:0]        CB_web;
  logic [L*CB_AW-1:0]  CB_addrb;
  logic [L*RSA_DW-1:0] CB_dinb_q;
  logic                wr_busy;
  logic                wr_done;
`ifdef CB_WR_ERR_EN
  logic                wr_err;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [L-1:0]        mask;
    logic [CB_AW-1:0]    addr;
    logic [L*RSA_DW-1:0] data;
  } wr_exp_t;

  wr_exp_t sb[$];

  // Reference model of the latched burst
  logic [1:0]       m_dir;
  logic [CB_AW-1:0] m_base;
  logic [LEN_W-1:0] m_len;
  logic [1:0]       m_lm;
  int               m_cnt;
  bit               m_active = 1'b0;

  cb_portb_wr_seq #(
    .L(L), .RSA_DW(RSA_DW), .CB_AW(CB_AW), .LEN_W(LEN_W)
  ) dut (
    .clk(clk), .sys_rst(sys_rst), .wr_start(wr_start),
    .wr_base_addr(wr_base_addr), .wr_len(wr_len), .wr_dir(wr_dir),
    .landmark_num_10(landmark_num_10), .in_valid(in_valid), .CB_dinb(CB_dinb),
    .CB_enb(CB_enb), .CB_web(CB_web), .CB_addrb(CB_addrb), .CB_dinb_q(CB_dinb_q),
    .wr_busy(wr_busy), .wr_done(wr_done)
`ifdef CB_WR_ERR_EN
    , .wr_err(wr_err)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Scoreboard: every registered write seen mid-cycle is popped and compared
  always @(negedge clk) begin
    if (sys_rst !== 1'b1 && (CB_enb !== '0 || CB_web !== '0)) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write enb=%b web=%b addrb=%h", CB_enb, CB_web, CB_addrb);
      end else begin
        wr_exp_t e;
        e = sb.pop_front();
        if (CB_enb !== e.mask || CB_web !== e.mask ||
            CB_addrb !== {L{e.addr}} || CB_dinb_q !== e.data) begin
          errors++;
          $display("FAIL write got enb=%b web=%b addrb=%h data=%h exp mask=%b addr=%0d data=%h",
                   CB_enb, CB_web, CB_addrb, CB_dinb_q, e.mask, e.addr, e.data);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [1:0] dir, input logic [CB_AW-1:0] base,
                       input logic [LEN_W-1:0] len, input logic [1:0] lm);
    wr_start = 1'b1; wr_dir = dir; wr_base_addr = base; wr_len = len; landmark_num_10 = lm;
    m_dir = dir; m_base = base; m_len = len; m_lm = lm; m_cnt = 0;
    m_active = (len != 0) && (dir != 2'b00);
    step();
    wr_start = 1'b0;
  endtask

  task automatic row(input bit v);
    logic [L*RSA_DW-1:0] d;
    wr_exp_t e;
    d = {$urandom, $urandom};
    in_valid = v;
    CB_dinb  = d;
    if (v && m_active) begin
      e.data = d;
      e.addr = (m_dir == 2'b10) ? m_base - CB_AW'(m_cnt) : m_base + CB_AW'(m_cnt);
      e.mask = (m_dir == 2'b11) ? (m_lm[1] ? 4'b0011 : 4'b1100) : 4'b1111;
      sb.push_back(e);
      m_cnt++;
      if (m_cnt == int'(m_len)) m_active = 1'b0;
    end
    step();
  endtask

  task automatic check_drained(input string name);
    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s pending_writes got %0d exp 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic check_flags(input string name, input logic busy, input logic done);
    checks++;
    if (wr_busy !== busy || wr_done !== done) begin
      errors++;
      $display("FAIL %s busy/done got %b%b exp %b%b", name, wr_busy, wr_done, busy, done);
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (CB_enb !== '0 || CB_web !== '0 || CB_addrb !== '0 || CB_dinb_q !== '0 ||
        wr_busy !== 1'b0 || wr_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got enb=%b web=%b addrb=%h dq=%h busy=%b done=%b exp all 0",
               CB_enb, CB_web, CB_addrb, CB_dinb_q, wr_busy, wr_done);
    end
    step();
    step();
    sys_rst = 1'b0;
    step();
  endtask

  task automatic test_pos();
    start(2'b01, 10'd5, 6'd3, 2'b00);
    check_flags("pos_busy", 1'b1, 1'b0);
    row(1); row(1); row(1);
    check_flags("pos_done", 1'b1, 1'b1);
    row(0);
    check_flags("pos_idle", 1'b0, 1'b0);
    check_drained("pos");
  endtask

  task automatic test_neg_wrap();
    start(2'b10, 10'd1, 6'd3, 2'b00);
    row(1); row(1); row(1);
    check_flags("neg_done", 1'b1, 1'b1);
    row(0);
    check_drained("neg");
  endtask

  task automatic test_new_lanes();
    start(2'b11, 10'd20, 6'd2, 2'b01);
    row(1); row(1);
    check_flags("new01_done", 1'b1, 1'b1);
    row(0);
    start(2'b11, 10'd20, 6'd2, 2'b10);
    row(1); row(0); row(1);
    check_flags("new10_done", 1'b1, 1'b1);
    row(0);
    check_drained("new");
  endtask

  task automatic test_len0_and_ignore();
    start(2'b01, 10'd40, 6'd0, 2'b00);
    check_flags("len0_done", 1'b1, 1'b1);
    row(1);
    check_flags("len0_idle", 1'b0, 1'b0);
    row(0);
    check_drained("len0");
    start(2'b01, 10'd100, 6'd2, 2'b00);
    row(1);
    wr_start = 1'b1; wr_base_addr = 10'd300; wr_dir = 2'b10; wr_len = 6'd5;
    row(1);
    wr_start = 1'b0;
    check_flags("ignore_done", 1'b1, 1'b1);
    row(0);
    check_flags("ignore_idle", 1'b0, 1'b0);
    check_drained("ignore");
  endtask

  task automatic test_midburst_reset();
    start(2'b01, 10'd50, 6'd4, 2'b00);
    row(1); row(1);
    in_valid = 1'b1;
    @(negedge clk);
    #1;
    sys_rst  = 1'b1;
    m_active = 1'b0;
    #1;
    checks++;
    if (CB_enb !== '0 || CB_web !== '0 || CB_addrb !== '0 || CB_dinb_q !== '0 ||
        wr_busy !== 1'b0 || wr_done !== 1'b0) begin
      errors++;
      $display("FAIL midburst_reset got enb=%b web=%b addrb=%h dq=%h busy=%b done=%b exp all 0",
               CB_enb, CB_web, CB_addrb, CB_dinb_q, wr_busy, wr_done);
    end
    step();
    sys_rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      row(1);
      checks++;
      if (CB_web !== '0 || wr_busy !== 1'b0) begin
        errors++;
        $display("FAIL post_reset_write cyc=%0d got web=%b busy=%b exp 0 0", i, CB_web, wr_busy);
      end
    end
    row(0);
    check_drained("post_reset");
    start(2'b01, 10'd7, 6'd1, 2'b00);
    row(1);
    check_flags("restart_done", 1'b1, 1'b1);
    row(0);
    check_drained("restart");
  endtask

`ifdef CB_WR_ERR_EN
  task automatic test_err();
    checks++;
    if (wr_err !== 1'b0) begin
      errors++;
      $display("FAIL err_initial got %b exp 0", wr_err);
    end
    row(1);
    row(0);
    row(0);
    checks++;
    if (wr_err !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky got %b exp 1", wr_err);
    end
    start(2'b01, 10'd0, 6'd1, 2'b00);
    checks++;
    if (wr_err !== 1'b0) begin
      errors++;
      $display("FAIL err_clear got %b exp 0", wr_err);
    end
    row(1);
    row(0);
    check_drained("err");
  endtask
`endif

  initial begin
    sys_rst = 1'b1; wr_start = 1'b0; wr_base_addr = '0; wr_len = '0; wr_dir = '0;
    landmark_num_10 = '0; in_valid = 1'b0; CB_dinb = '0;
    test_reset();
    test_pos();
    test_neg_wrap();
    test_new_lanes();
    test_len0_and_ignore();
    test_midburst_reset();
`ifdef CB_WR_ERR_EN
    test_err();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
